regfile_nport: RTL and testbench

Parametrised multi-port register file for the processor datapath; it supersedes the fixed 32-entry, 32-bit, single-read-port select tree. Storage depth, data width and read-port count are parameters. Reads are combinational. An optional write-to-read bypass removes the decode/writeback hazard, and register 0 can optionally be hard-wired to zero. One synchronous write port updates storage on the rising clock edge.

---
 rtl/regfile_nport.sv | 66 ++++++
 tb/tb_regfile_nport.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_nport.sv
// Parametrised register file: one synchronous write port and NUM_READ combinational
// read ports, each a balanced 2:1 mux tree, with optional write bypass and zero register.
module regfile_nport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_READ = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [NUM_READ*ADDR_W-1:0] raddr,
  output logic [NUM_READ*WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en;

  // Discarded writes to the zero register never reach storage nor the bypass path.
  assign wr_en = we && !reset && !(ZERO_REG && (waddr == '0));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (wr_en) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic [WIDTH-1:0]  rd;
    logic [WIDTH-1:0]  lvl [ADDR_W+1][DEPTH];

    assign ra = raddr[p*ADDR_W +: ADDR_W];

    // Level l halves the candidates using address bit l, LSB first.
    always_comb begin
      for (int l = 0; l <= ADDR_W; l++) begin
        for (int i = 0; i < DEPTH; i++) lvl[l][i] = '0;
      end
      for (int i = 0; i < DEPTH; i++) lvl[0][i] = mem_q[i];
      for (int l = 0; l < ADDR_W; l++) begin
        for (int i = 0; i < (DEPTH >> (l + 1)); i++) begin
          lvl[l+1][i] = ra[l] ? lvl[l][2*i+1] : lvl[l][2*i];
        end
      end
      rd = lvl[ADDR_W][0];
      if (BYPASS && wr_en && (waddr == ra)) rd = wdata;
      if (ZERO_REG && (ra == '0)) rd = '0;
    end

    assign rdata[p*WIDTH +: WIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_nport.sv
// Scoreboard bench for regfile_nport: three parameterisations, directed vectors
// plus a randomised run of the small instance against a reference array.
module tb_regfile_nport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for instance a (bypass, 4 ports) and b (no bypass, 2 ports)
  logic         rst_ab, we_ab;
  logic [4:0]   waddr_ab;
  logic [31:0]  wdata_ab;
  logic [19:0]  raddr_a;
  logic [127:0] rdata_a;
  logic [9:0]   raddr_b;
  logic [63:0]  rdata_b;

  // Instance c: 8-bit, 16-entry, one port, ordinary reg0, bypass on
  logic         rst_c, we_c;
  logic [3:0]   waddr_c, raddr_c;
  logic [7:0]   wdata_c, rdata_c;

  regfile_nport #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .NUM_READ(4), .BYPASS(1'b1), .ZERO_REG(1'b1))
    dut_a (.clock(clk), .reset(rst_ab), .we(we_ab), .waddr(waddr_ab), .wdata(wdata_ab),
           .raddr(raddr_a), .rdata(rdata_a));

  regfile_nport #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .NUM_READ(2), .BYPASS(1'b0), .ZERO_REG(1'b1))
    dut_b (.clock(clk), .reset(rst_ab), .we(we_ab), .waddr(waddr_ab), .wdata(wdata_ab),
           .raddr(raddr_b), .rdata(rdata_b));

  regfile_nport #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .NUM_READ(1), .BYPASS(1'b1), .ZERO_REG(1'b0))
    dut_c (.clock(clk), .reset(rst_c), .we(we_c), .waddr(waddr_c), .wdata(wdata_c),
           .raddr(raddr_c), .rdata(rdata_c));

  typedef struct {
    int          sel;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] ref_c [16];

  function automatic void push(int sel, int port, logic [31:0] exp, string name);
    exp_t e;
    e.sel = sel; e.port = port; e.exp = exp; e.name = name;
    sb_q.push_back(e);
  endfunction

  function automatic logic [31:0] get_out(int sel, int port);
    case (sel)
      0:       return rdata_a[port*32 +: 32];
      1:       return rdata_b[port*32 +: 32];
      default: return {24'h0, rdata_c};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ra_a(int p, int a);
    raddr_a[p*5 +: 5] = a[4:0];
  endtask

  task automatic ra_b(int p, int a);
    raddr_b[p*5 +: 5] = a[4:0];
  endtask

  // Monitor: read ports are combinational, so every queued expectation is
  // compared at the falling edge of the cycle in which it was issued.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = get_out(e.sel, e.port);
      n_checks++;
      if (got === e.exp) n_pass++;
      else $display("FAIL %s dut%0d port%0d: got %h expected %h", e.name, e.sel, e.port, got, e.exp);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev, val, expv;
    rst_ab = 1'b1; we_ab = 1'b0; waddr_ab = '0; wdata_ab = '0; raddr_a = '0; raddr_b = '0;
    rst_c = 1'b1; we_c = 1'b0; waddr_c = '0; wdata_c = '0; raddr_c = '0;

    step();
    rst_ab = 1'b0; rst_c = 1'b0;
    for (int p = 0; p < 4; p++) begin ra_a(p, p + 1); push(0, p, 32'h0, "reset_state_a"); end
    for (int p = 0; p < 2; p++) begin ra_b(p, p + 1); push(1, p, 32'h0, "reset_state_b"); end

    for (int k = 1; k < 32; k++) begin
      step(); we_ab = 1'b1; waddr_ab = k[4:0]; wdata_ab = 32'hDEADBEEF;
    end

    // Reset with a concurrent write: bypass suppressed, old contents visible
    step(); rst_ab = 1'b1; we_ab = 1'b1; waddr_ab = 5'd5; wdata_ab = 32'h0000_1234;
    ra_a(0, 5); ra_a(1, 31); ra_b(0, 5);
    push(0, 0, 32'hDEADBEEF, "reset_cycle_no_bypass_a");
    push(0, 1, 32'hDEADBEEF, "reset_cycle_last_write_a");
    push(1, 0, 32'hDEADBEEF, "reset_cycle_b");

    for (int k = 0; k < 16; k++) begin
      step(); rst_ab = 1'b0; we_ab = 1'b0;
      ra_a(0, k); ra_a(1, k + 16); ra_a(2, 31 - k); ra_a(3, 15 - k);
      ra_b(0, k); ra_b(1, k + 16);
      for (int p = 0; p < 4; p++) push(0, p, 32'h0, "reset_clear_a");
      for (int p = 0; p < 2; p++) push(1, p, 32'h0, "reset_clear_b");
    end

    for (int k = 1; k < 32; k++) begin
      step(); we_ab = 1'b1; waddr_ab = k[4:0]; wdata_ab = 32'hA500_0000 | k;
      ra_a(0, k); ra_b(0, k);
      push(0, 0, 32'hA500_0000 | k, "write_bypass_a");
      push(1, 0, 32'h0, "write_no_bypass_b");
    end

    step(); we_ab = 1'b1; waddr_ab = 5'd0; wdata_ab = 32'hFFFF_FFFF;
    ra_a(0, 0); ra_b(0, 0);
    push(0, 0, 32'h0, "zero_write_during_a");
    push(1, 0, 32'h0, "zero_write_during_b");

    for (int k = 0; k < 32; k++) begin
      step(); we_ab = 1'b0;
      ra_a(0, k); ra_a(1, 31 - k); ra_a(2, k); ra_a(3, 31 - k);
      ra_b(0, k); ra_b(1, 31 - k);
      expv = (k == 0) ? 32'h0 : (32'hA500_0000 | k);
      push(0, 0, expv, "sweep_up_a"); push(0, 2, expv, "sweep_up_a");
      push(1, 0, expv, "sweep_up_b");
      expv = (k == 31) ? 32'h0 : (32'hA500_0000 | (31 - k));
      push(0, 1, expv, "sweep_down_a"); push(0, 3, expv, "sweep_down_a");
      push(1, 1, expv, "sweep_down_b");
    end

    step(); we_ab = 1'b1; waddr_ab = 5'd7; wdata_ab = 32'h1111_1111;
    step(); wdata_ab = 32'h2222_2222;
    for (int p = 0; p < 4; p++) begin ra_a(p, 7); push(0, p, 32'h2222_2222, "bypass_during_a"); end
    ra_b(0, 7); push(1, 0, 32'h1111_1111, "no_bypass_old_b");
    step(); we_ab = 1'b0;
    push(0, 0, 32'h2222_2222, "bypass_after_a");
    push(1, 0, 32'h2222_2222, "no_bypass_after_b");

    step(); we_ab = 1'b1; waddr_ab = 5'd0; wdata_ab = 32'hCAFE_F00D;
    ra_a(0, 0); ra_b(0, 0);
    push(0, 0, 32'h0, "zero_over_bypass_during");
    push(1, 0, 32'h0, "zero_no_bypass_during");
    step(); we_ab = 1'b0;
    push(0, 0, 32'h0, "zero_over_bypass_after");
    push(1, 0, 32'h0, "zero_no_bypass_after");

    step(); we_ab = 1'b1; waddr_ab = 5'd3; wdata_ab = 32'h0F0F_0F0F;
    for (int p = 0; p < 4; p++) begin ra_a(p, 3); push(0, p, 32'h0F0F_0F0F, "ports_first_write"); end
    ra_b(0, 3); push(1, 0, 32'hA500_0003, "ports_old_b");
    step(); wdata_ab = 32'hF0F0_F0F0;
    for (int p = 0; p < 4; p++) push(0, p, 32'hF0F0_F0F0, "ports_rewrite");
    push(1, 0, 32'h0F0F_0F0F, "ports_rewrite_b");
    step(); we_ab = 1'b0;
    for (int p = 0; p < 4; p++) push(0, p, 32'hF0F0_F0F0, "ports_after");
    push(1, 0, 32'hF0F0_F0F0, "ports_after_b");

    prev = 32'hA500_0009;
    for (int v = 1; v <= 3; v++) begin
      val = 32'h0101_0101 * v;
      step(); we_ab = 1'b1; waddr_ab = 5'd9; wdata_ab = val;
      ra_a(1, 9); ra_b(1, 9);
      push(0, 1, val, "b2b_bypass_a");
      push(1, 1, prev, "b2b_prev_b");
      prev = val;
    end
    step(); we_ab = 1'b0;
    push(0, 1, prev, "b2b_last_a");
    push(1, 1, prev, "b2b_last_b");

    step(); we_c = 1'b1; waddr_c = 4'd0; wdata_c = 8'h5A; raddr_c = 4'd0;
    push(2, 0, 32'h5A, "c_reg0_bypass");
    step(); waddr_c = 4'd15; wdata_c = 8'hC3; raddr_c = 4'd0;
    push(2, 0, 32'h5A, "c_reg0_stored");
    step(); we_c = 1'b0; raddr_c = 4'd15;
    push(2, 0, 32'hC3, "c_reg15");

    for (int i = 0; i < 16; i++) ref_c[i] = 8'h0;
    ref_c[0] = 8'h5A; ref_c[15] = 8'hC3;
    for (int n = 0; n < 10000; n++) begin
      step();
      rst_c   = ($urandom_range(0, 99) == 0);
      we_c    = 1'($urandom_range(0, 1));
      waddr_c = 4'($urandom_range(0, 15));
      wdata_c = 8'($urandom_range(0, 255));
      raddr_c = 4'($urandom_range(0, 15));
      if (!rst_c && we_c && (waddr_c == raddr_c)) push(2, 0, {24'h0, wdata_c}, "c_random");
      else push(2, 0, {24'h0, ref_c[raddr_c]}, "c_random");
      if (rst_c) begin
        for (int i = 0; i < 16; i++) ref_c[i] = 8'h0;
      end else if (we_c) begin
        ref_c[waddr_c] = wdata_c;
      end
    end

    step(); rst_c = 1'b0; we_c = 1'b0;
    step();
    step();
    if (sb_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    if (n_checks == 0)
      $display("FAIL check_count: got 0 checks expected more than 0");
    if (n_pass != n_checks)
      $display("FAIL summary: got %0d passes expected %0d", n_pass, n_checks);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
